imem_program_loader: RTL and testbench

- Upstream feeder for the low/high 16x16 instruction-memory register-file banks.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 16-bit instruction words, and issues one write per word. Write outputs: IMEM_INPUT, WRITE_SELECT, and per-bank write enables.
- Holds the CPU while loading, verifies an 8-bit checksum, and reports done or error.

---
 rtl/imem_program_loader.sv | 193 +++++++++++++++++++
 tb/tb_imem_program_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: byte-stream loader feeding the low/high 16x16
// instruction-memory banks.
//
// A load is a count byte N (0 or >=32 means 32 words), 2N little-endian data
// bytes, and an 8-bit wrap-around checksum of the data bytes. Each assembled
// word is committed with a one-cycle strobe to the low bank (addr[4]=0) or
// the high bank (addr[4]=1). The CPU is held for the whole load. Successful
// completion pulses LOAD_DONE. A checksum mismatch or an idle timeout sets
// the sticky LOAD_ERROR flag.
//
// Ports:
//   CLOCK, RESET        clock, asynchronous active-low reset
//   LOAD_START          request a load (honoured only in IDLE)
//   BYTE_IN/BYTE_VALID  incoming byte stream
//   BYTE_READY          loader accepts a byte this cycle
//   IMEM_INPUT          assembled instruction word
//   WRITE_SELECT        word index within the selected bank
//   WRITE_ENABLE_LOW    write strobe, low bank
//   WRITE_ENABLE_HIGH   write strobe, high bank
//   CPU_HOLD            CPU stall while the loader is busy
//   LOAD_DONE           one-cycle success pulse
//   LOAD_ERROR          sticky failure flag
module imem_program_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        LOAD_START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic [15:0] IMEM_INPUT,
  output logic [3:0]  WRITE_SELECT,
  output logic        WRITE_ENABLE_LOW,
  output logic        WRITE_ENABLE_HIGH,
  output logic        CPU_HOLD,
  output logic        LOAD_DONE,
  output logic        LOAD_ERROR
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WORD_W = 16;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LO,
    S_HI,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        n_q;
  logic [7:0]               csum_q;
  logic [WORD_W-1:0]        word_q;
  logic [TIMEOUT_WIDTH-1:0] tcnt_q;

  logic                     accept_c;
  logic                     rx_state_c;
  logic                     timeout_c;
  logic [ADDR_W-1:0]        addr_inc_c;
  logic [ADDR_W-1:0]        n_decode_c;
  logic                     next_rx_c;

  // Byte handshake and timeout detection.
  always_comb begin
    rx_state_c = (state == S_COUNT) || (state == S_LO) ||
                 (state == S_HI)    || (state == S_CHECK);
    accept_c   = BYTE_VALID && BYTE_READY;
    timeout_c  = rx_state_c && !accept_c && (tcnt_q == TIMEOUT_LAST);
    addr_inc_c = addr_q + ADDR_W'(1);
    // 0 and anything >= 32 both mean a full 32-word load.
    if ((BYTE_IN == 8'd0) || (BYTE_IN >= 8'd32)) begin
      n_decode_c = ADDR_W'(32);
    end else begin
      n_decode_c = ADDR_W'(BYTE_IN[4:0]);
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a timeout overrides any other transition.
  always_comb begin
    next_state = state;
    next_rx_c  = 1'b0;
    case (state)
      S_IDLE:  if (LOAD_START) next_state = S_COUNT;
      S_COUNT: if (accept_c) next_state = S_LO;
      S_LO:    if (accept_c) next_state = S_HI;
      S_HI:    if (accept_c) next_state = S_WRITE;
      S_WRITE: next_state = (addr_inc_c == n_q) ? S_CHECK : S_LO;
      S_CHECK: begin
        if (accept_c) begin
          next_state = (BYTE_IN == csum_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE:  next_state = S_IDLE;
      S_ERROR: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (timeout_c) begin
      next_state = S_ERROR;
    end
    next_rx_c = (next_state == S_COUNT) || (next_state == S_LO) ||
                (next_state == S_HI)    || (next_state == S_CHECK);
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      addr_q            <= '0;
      n_q               <= '0;
      csum_q            <= '0;
      word_q            <= '0;
      tcnt_q            <= '0;
      BYTE_READY        <= 1'b0;
      IMEM_INPUT        <= '0;
      WRITE_SELECT      <= '0;
      WRITE_ENABLE_LOW  <= 1'b0;
      WRITE_ENABLE_HIGH <= 1'b0;
      CPU_HOLD          <= 1'b0;
      LOAD_DONE         <= 1'b0;
      LOAD_ERROR        <= 1'b0;
    end else begin
      // Ready and hold track the state being entered so they line up with it.
      BYTE_READY        <= next_rx_c;
      CPU_HOLD          <= (next_state != S_IDLE);
      WRITE_ENABLE_LOW  <= 1'b0;
      WRITE_ENABLE_HIGH <= 1'b0;
      LOAD_DONE         <= (state == S_DONE);

      // Idle counter runs only while waiting for a byte.
      if (rx_state_c && !accept_c && !timeout_c) begin
        tcnt_q <= tcnt_q + TIMEOUT_WIDTH'(1);
      end else begin
        tcnt_q <= '0;
      end

      case (state)
        S_IDLE: begin
          if (LOAD_START) LOAD_ERROR <= 1'b0;
        end
        S_COUNT: begin
          if (accept_c) begin
            n_q    <= n_decode_c;
            addr_q <= '0;
            csum_q <= '0;
          end
        end
        S_LO: begin
          if (accept_c) begin
            word_q[7:0] <= BYTE_IN;
            csum_q      <= csum_q + BYTE_IN;
          end
        end
        S_HI: begin
          if (accept_c) begin
            word_q[15:8] <= BYTE_IN;
            csum_q       <= csum_q + BYTE_IN;
          end
        end
        S_WRITE: begin
          IMEM_INPUT        <= word_q;
          WRITE_SELECT      <= addr_q[3:0];
          WRITE_ENABLE_LOW  <= ~addr_q[4];
          WRITE_ENABLE_HIGH <= addr_q[4];
          addr_q            <= addr_inc_c;
        end
        S_ERROR: begin
          LOAD_ERROR <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] imem_input;
  logic [3:0]  write_select;
  logic        we_low;
  logic        we_high;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int checks   = 0;
  int failures = 0;

  // Expected writes: {high_bank, select, data}
  logic [20:0] exp_q[$];
  logic [15:0] tb_words[32];

  int lo_cnt   = 0;
  int hi_cnt   = 0;
  int done_cnt = 0;
  logic prev_ready = 1'b0;

  imem_program_loader #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_WIDTH (4)
  ) dut (
    .CLOCK            (clk),
    .RESET            (rst_n),
    .LOAD_START       (load_start),
    .BYTE_IN          (byte_in),
    .BYTE_VALID       (byte_valid),
    .BYTE_READY       (byte_ready),
    .IMEM_INPUT       (imem_input),
    .WRITE_SELECT     (write_select),
    .WRITE_ENABLE_LOW (we_low),
    .WRITE_ENABLE_HIGH(we_high),
    .CPU_HOLD         (cpu_hold),
    .LOAD_DONE        (load_done),
    .LOAD_ERROR       (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    logic [20:0] e;
    logic [20:0] got;
    if (we_low || we_high) begin
      got = {we_high, write_select, imem_input};
      checks++;
      if (we_low && we_high) begin
        failures++;
        $display("FAIL both_strobes: low=%0b high=%0b required only one", we_low, we_high);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got hi=%0b sel=%0d data=%h, none expected",
                 we_high, write_select, imem_input);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL write_data: got hi=%0b sel=%0d data=%h required hi=%0b sel=%0d data=%h",
                   got[20], got[19:16], got[15:0], e[20], e[19:16], e[15:0]);
        end
      end
      // The cycle before a strobe is the WRITE state, which never accepts bytes.
      checks++;
      if (prev_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_write: BYTE_READY=%0b required 0", prev_ready);
      end
      if (we_low)  lo_cnt++;
      if (we_high) hi_cnt++;
    end
    if (load_done) done_cnt++;
    prev_ready = byte_ready;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL byte_accept: byte %h not accepted within 40 cycles", b);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic load_stream(input logic [7:0] nb, input int nw,
                             input logic [7:0] cs, input int maxgap);
    logic [4:0] a;
    for (int i = 0; i < nw; i++) begin
      a = 5'(i);
      exp_q.push_back({a[4], a[3:0], tb_words[i]});
    end
    send_byte(nb, $urandom_range(0, maxgap));
    for (int i = 0; i < nw; i++) begin
      send_byte(tb_words[i][7:0],  $urandom_range(0, maxgap));
      send_byte(tb_words[i][15:8], $urandom_range(0, maxgap));
    end
    send_byte(cs, $urandom_range(0, maxgap));
    byte_valid = 1'b0;
  endtask

  task automatic wait_end(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (load_done || load_error) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({byte_ready, imem_input, write_select, we_low, we_high, cpu_hold,
         load_done, load_error} !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%0b data=%h sel=%0d lo=%0b hi=%0b hold=%0b done=%0b err=%0b required all 0",
               byte_ready, imem_input, write_select, we_low, we_high, cpu_hold, load_done, load_error);
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: hold=%0b ready=%0b required 0 0", cpu_hold, byte_ready);
    end
  endtask

  task automatic test_single_word();
    bit seen;
    int lo0 = lo_cnt, d0 = done_cnt;
    tb_words[0] = 16'h1234;
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_rise: CPU_HOLD=%0b required 1", cpu_hold);
    end
    load_stream(8'h01, 1, 8'h46, 0);
    wait_end(seen);
    checks++;
    if (!seen || load_done !== 1'b1 || load_error !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL single_done: seen=%0b done=%0b err=%0b hold=%0b required 1 1 0 0",
               seen, load_done, load_error, cpu_hold);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (lo_cnt - lo0 != 1 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_counts: writes=%0d dones=%0d pending=%0d required 1 1 0",
               lo_cnt - lo0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_full_load();
    bit seen;
    logic [7:0] cs = 8'd0;
    int lo0 = lo_cnt, hi0 = hi_cnt, d0 = done_cnt;
    for (int i = 0; i < 32; i++) begin
      tb_words[i] = 16'(i);
      cs = cs + tb_words[i][7:0] + tb_words[i][15:8];
    end
    pulse_start();
    load_stream(8'h00, 32, cs, 0);
    wait_end(seen);
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || load_error !== 1'b0 || lo_cnt - lo0 != 16 || hi_cnt - hi0 != 16 ||
        done_cnt - d0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_load: seen=%0b err=%0b lo=%0d hi=%0d dones=%0d pending=%0d required 1 0 16 16 1 0",
               seen, load_error, lo_cnt - lo0, hi_cnt - hi0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    bit seen;
    int lo0 = lo_cnt, d0 = done_cnt;
    tb_words[0] = 16'h1234;
    pulse_start();
    load_stream(8'h01, 1, 8'h47, 0);
    wait_end(seen);
    repeat (5) @(negedge clk);
    checks++;
    if (!seen || load_error !== 1'b1 || cpu_hold !== 1'b0 || done_cnt != d0 ||
        lo_cnt - lo0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_checksum: seen=%0b err=%0b hold=%0b dones=%0d writes=%0d pending=%0d required 1 1 0 0 1 0",
               seen, load_error, cpu_hold, done_cnt - d0, lo_cnt - lo0, exp_q.size());
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL error_clear: err=%0b hold=%0b required 0 1", load_error, cpu_hold);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [7:0] cs = 8'd0;
    int lo0 = lo_cnt, d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      tb_words[i] = 16'($urandom);
      cs = cs + tb_words[i][7:0] + tb_words[i][15:8];
    end
    pulse_start();
    load_stream(8'h03, 3, cs, 5);
    wait_end(seen);
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || load_error !== 1'b0 || lo_cnt - lo0 != 3 || done_cnt - d0 != 1 ||
        exp_q.size() != 0) begin
      failures++;
      $display("FAIL gaps_load: seen=%0b err=%0b writes=%0d dones=%0d pending=%0d required 1 0 3 1 0",
               seen, load_error, lo_cnt - lo0, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int w0 = lo_cnt + hi_cnt;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    byte_valid = 1'b0;
    wait_end(seen);
    checks++;
    if (!seen || load_error !== 1'b1 || cpu_hold !== 1'b0 ||
        (lo_cnt + hi_cnt) != w0) begin
      failures++;
      $display("FAIL timeout: seen=%0b err=%0b hold=%0b writes=%0d required 1 1 0 0",
               seen, load_error, cpu_hold, lo_cnt + hi_cnt - w0);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_load();
    logic [4:0] a = 5'd0;
    int w0 = lo_cnt + hi_cnt;
    tb_words[0] = 16'hBEEF;
    tb_words[1] = 16'hCAFE;
    exp_q.push_back({a[4], a[3:0], tb_words[0]});
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(tb_words[0][7:0], 0);
    send_byte(tb_words[0][15:8], 0);
    send_byte(tb_words[1][7:0], 0);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, imem_input, write_select, we_low, we_high, cpu_hold,
         load_done, load_error} !== 26'd0) begin
      failures++;
      $display("FAIL async_reset: ready=%0b data=%h sel=%0d lo=%0b hi=%0b hold=%0b done=%0b err=%0b required all 0",
               byte_ready, imem_input, write_select, we_low, we_high, cpu_hold, load_done, load_error);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ((lo_cnt + hi_cnt) - w0 != 1 || exp_q.size() != 0 || cpu_hold !== 1'b0 ||
        byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load: writes=%0d pending=%0d hold=%0b ready=%0b required 1 0 0 0",
               lo_cnt + hi_cnt - w0, exp_q.size(), cpu_hold, byte_ready);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    test_reset();
    test_single_word();
    test_full_load();
    test_bad_checksum();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
